// File: rtl/ir_nec_pkg.sv
// Shared types and default timing for the NEC IR transmit path.
// Default counts assume a 50 MHz clock.
package ir_nec_pkg;

  localparam int unsigned NEC_FRAME_BITS = 32;
  localparam int unsigned TIMER_W        = 22;

  localparam int unsigned LEAD_MARK_CNT_DEF  = 450000;
  localparam int unsigned LEAD_SPACE_CNT_DEF = 225000;
  localparam int unsigned BIT_MARK_CNT_DEF   = 28125;
  localparam int unsigned ZERO_SPACE_CNT_DEF = 28125;
  localparam int unsigned ONE_SPACE_CNT_DEF  = 84375;
  localparam int unsigned GAP_CNT_DEF        = 2000000;
  localparam int unsigned CARRIER_PERIOD_DEF = 1316;
  localparam int unsigned CARRIER_HIGH_DEF   = 439;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StGap
  } nec_state_e;

  function automatic logic is_mark(input nec_state_e s);
    return (s == StLeadMark) || (s == StBitMark) || (s == StStopMark);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running carrier with a phase reset, so each burst starts on a high phase.
// Only instantiated when IR_TX_CARRIER_EN is defined.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_PERIOD = 1316,
  parameter int unsigned CARRIER_HIGH   = 439
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_rst,
  output logic carrier
);

  localparam int unsigned CntW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (phase_rst || (cnt_q == CntW'(CARRIER_PERIOD - 1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier = (32'(cnt_q) < CARRIER_HIGH);

endmodule

// File: rtl/ir_transmit_nec.sv
// NEC IR transmitter: leader, 32 pulse-distance bits (LSB first), stop mark, then idle gap.
// Define IR_TX_CARRIER_EN to modulate ir_out with the carrier; otherwise ir_out = ir_env.
module ir_transmit_nec
  import ir_nec_pkg::*;
#(
  parameter int unsigned LEAD_MARK_CNT  = LEAD_MARK_CNT_DEF,
  parameter int unsigned LEAD_SPACE_CNT = LEAD_SPACE_CNT_DEF,
  parameter int unsigned BIT_MARK_CNT   = BIT_MARK_CNT_DEF,
  parameter int unsigned ZERO_SPACE_CNT = ZERO_SPACE_CNT_DEF,
  parameter int unsigned ONE_SPACE_CNT  = ONE_SPACE_CNT_DEF,
  parameter int unsigned GAP_CNT        = GAP_CNT_DEF
`ifdef IR_TX_CARRIER_EN
  ,
  parameter int unsigned CARRIER_PERIOD = CARRIER_PERIOD_DEF,
  parameter int unsigned CARRIER_HIGH   = CARRIER_HIGH_DEF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        ir_env,
  output logic        ir_out
);

  nec_state_e                state_q, state_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [NEC_FRAME_BITS-1:0] shift_q, shift_d;
  logic [5:0]                bit_cnt_q, bit_cnt_d;
  logic                      ir_env_q, tx_done_q;
  logic [TIMER_W-1:0]        phase_last;
  logic                      phase_end;

  // Last timer value of the current phase; a phase of N cycles ends at N-1.
  always_comb begin
    case (state_q)
      StLeadMark:  phase_last = TIMER_W'(LEAD_MARK_CNT - 1);
      StLeadSpace: phase_last = TIMER_W'(LEAD_SPACE_CNT - 1);
      StBitMark:   phase_last = TIMER_W'(BIT_MARK_CNT - 1);
      StBitSpace:  phase_last = shift_q[0] ? TIMER_W'(ONE_SPACE_CNT - 1)
                                           : TIMER_W'(ZERO_SPACE_CNT - 1);
      StStopMark:  phase_last = TIMER_W'(BIT_MARK_CNT - 1);
      StGap:       phase_last = TIMER_W'(GAP_CNT - 1);
      default:     phase_last = '0;
    endcase
  end

  assign phase_end = (timer_q == phase_last);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d   = StLeadMark;
          shift_d   = tx_data;
          bit_cnt_d = '0;
        end
      end
      StLeadMark:  if (phase_end) state_d = StLeadSpace;
      StLeadSpace: if (phase_end) state_d = StBitMark;
      StBitMark:   if (phase_end) state_d = StBitSpace;
      StBitSpace: begin
        if (phase_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'(NEC_FRAME_BITS - 1)) ? StStopMark : StBitMark;
        end
      end
      StStopMark:  if (phase_end) state_d = StGap;
      StGap:       if (phase_end) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    // Timer restarts from zero on every state entry and idles at zero.
    timer_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ir_env_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ir_env_q  <= is_mark(state_d);
      tx_done_q <= (state_q == StGap) && phase_end;
    end
  end

  assign tx_ready = (state_q == StIdle);
  assign tx_done  = tx_done_q;
  assign ir_env   = ir_env_q;

`ifdef IR_TX_CARRIER_EN
  logic mark_entry;
  logic carrier;

  assign mark_entry = is_mark(state_d) && (state_d != state_q);

  ir_carrier_gen #(
    .CARRIER_PERIOD (CARRIER_PERIOD),
    .CARRIER_HIGH   (CARRIER_HIGH)
  ) u_carrier (
    .clk       (clk),
    .rst       (rst),
    .phase_rst (mark_entry),
    .carrier   (carrier)
  );

  assign ir_out = ir_env_q & carrier;
`else
  assign ir_out = ir_env_q;
`endif

endmodule

// File: tb/tb_ir_transmit_nec.sv
// Directed bench for ir_transmit_nec with shortened timing so whole frames fit in a short run.
// Honours IR_TX_CARRIER_EN when checking ir_out.
module tb_ir_transmit_nec;

  localparam int unsigned LM   = 16;
  localparam int unsigned LS   = 8;
  localparam int unsigned BM   = 2;
  localparam int unsigned ZS   = 2;
  localparam int unsigned OS   = 5;
  localparam int unsigned GAP  = 12;
  localparam int unsigned NONE = 32'hFFFF_FFFF;
`ifdef IR_TX_CARRIER_EN
  localparam int unsigned CP = 5;
  localparam int unsigned CH = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready, tx_done, ir_env, ir_out;

  int n_tests = 0;
  int n_fail  = 0;

  ir_transmit_nec #(
    .LEAD_MARK_CNT  (LM),
    .LEAD_SPACE_CNT (LS),
    .BIT_MARK_CNT   (BM),
    .ZERO_SPACE_CNT (ZS),
    .ONE_SPACE_CNT  (OS),
    .GAP_CNT        (GAP)
`ifdef IR_TX_CARRIER_EN
    ,
    .CARRIER_PERIOD (CP),
    .CARRIER_HIGH   (CH)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .ir_env   (ir_env),
    .ir_out   (ir_out)
  );

  always #5 clk = ~clk;

  // Expected LED drive at cycle k of a segment at envelope level lvl.
  function automatic logic exp_out(input logic lvl, input int unsigned k);
`ifdef IR_TX_CARRIER_EN
    return lvl && ((k % CP) < CH);
`else
    if (k > 32'hFFFF_FFF0) return 1'bx;
    return lvl;
`endif
  endfunction

  // Call at a negedge in IDLE; returns at the negedge of leader cycle 0.
  task automatic send(input logic [31:0] word);
    tx_valid = 1'b1;
    tx_data  = word;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Checks a whole frame plus gap, starting at leader cycle 0; ends on the tx_done cycle.
  task automatic check_frame(input logic [31:0] word, input string name,
                             input int unsigned pulse_at, input logic hold,
                             input logic [31:0] next_word);
    int unsigned cyc;
    logic        bad;
    cyc = 0;
    for (int s = 0; s < 67; s++) begin
      logic        lvl;
      int unsigned len;
      if (s == 0) begin
        lvl = 1'b1; len = LM;
      end else if (s == 1) begin
        lvl = 1'b0; len = LS;
      end else if (s == 66 || (s % 2) == 0) begin
        lvl = 1'b1; len = BM;
      end else begin
        lvl = 1'b0; len = word[(s - 3) / 2] ? OS : ZS;
      end
      bad = 1'b0;
      for (int unsigned k = 0; k < len; k++) begin
        tx_valid = hold || (cyc == pulse_at);
        if (hold) tx_data = next_word;
        else if (cyc == pulse_at) tx_data = ~word;
        if (!bad && (ir_env !== lvl || ir_out !== exp_out(lvl, k) ||
                     tx_ready !== 1'b0 || tx_done !== 1'b0)) begin
          bad = 1'b1;
          $display("FAIL %s seg %0d cyc %0d: env=%b out=%b ready=%b done=%b, want env=%b out=%b ready=0 done=0",
                   name, s, k, ir_env, ir_out, tx_ready, tx_done, lvl, exp_out(lvl, k));
        end
        cyc++;
        @(negedge clk);
      end
      n_tests++;
      if (bad) n_fail++;
    end
    bad = 1'b0;
    for (int unsigned k = 0; k < GAP; k++) begin
      tx_valid = hold;
      if (!bad && (ir_env !== 1'b0 || ir_out !== 1'b0 || tx_ready !== 1'b0 ||
                   tx_done !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL %s gap cyc %0d: env=%b out=%b ready=%b done=%b, want all 0",
                 name, k, ir_env, ir_out, tx_ready, tx_done);
      end
      @(negedge clk);
    end
    n_tests++;
    if (bad) n_fail++;
    n_tests++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b1 || ir_env !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: done=%b ready=%b env=%b, want done=1 ready=1 env=0",
               name, tx_done, tx_ready, ir_env);
    end
  endtask

  // After a frame's tx_done cycle with tx_valid low: stays idle, no second pulse.
  task automatic check_idle_after(input string name);
    logic bad;
    bad = 1'b0;
    tx_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!bad && (tx_done !== 1'b0 || tx_ready !== 1'b1 || ir_env !== 1'b0 ||
                   ir_out !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL %s idle cyc %0d: done=%b ready=%b env=%b out=%b, want 0 1 0 0",
                 name, k, tx_done, tx_ready, ir_env, ir_out);
      end
    end
    n_tests++;
    if (bad) n_fail++;
  endtask

  task automatic test_reset();
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!bad && (tx_ready !== 1'b1 || tx_done !== 1'b0 || ir_env !== 1'b0 ||
                   ir_out !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL reset cyc %0d: ready=%b done=%b env=%b out=%b, want 1 0 0 0",
                 k, tx_ready, tx_done, ir_env, ir_out);
      end
    end
    n_tests++;
    if (bad) n_fail++;
  endtask

  task automatic test_zero_word();
    send(32'h0000_0000);
    check_frame(32'h0000_0000, "zero", NONE, 1'b0, 32'h0);
    check_idle_after("zero");
  endtask

  task automatic test_ones_ignore_valid();
    send(32'hFFFF_FFFF);
    check_frame(32'hFFFF_FFFF, "ones", 40, 1'b0, 32'h0);
    check_idle_after("ones");
  endtask

  task automatic measure(input logic lvl, output int unsigned n);
    n = 0;
    while (ir_env === lvl && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Receiver-style decode: bit i is 1 when its space is long.
  task automatic test_loopback();
    logic [31:0] word;
    int unsigned lm, ls, m, sp, stop, dones;
    logic        mark_bad;
    word = '0;
    mark_bad = 1'b0;
    send(32'hEF10_00FF);
    measure(1'b1, lm);
    measure(1'b0, ls);
    for (int i = 0; i < 32; i++) begin
      measure(1'b1, m);
      measure(1'b0, sp);
      if (m != BM) mark_bad = 1'b1;
      word[i] = (sp > (ZS + OS) / 2);
    end
    measure(1'b1, stop);
    n_tests++;
    if (lm != LM || ls != LS) begin
      n_fail++;
      $display("FAIL loop_leader: mark=%0d space=%0d, want %0d %0d", lm, ls, LM, LS);
    end
    n_tests++;
    if (word !== 32'hEF10_00FF || mark_bad) begin
      n_fail++;
      $display("FAIL loop_data: got %h markbad=%b, want ef1000ff markbad=0", word, mark_bad);
    end
    n_tests++;
    if (stop != BM) begin
      n_fail++;
      $display("FAIL loop_stop: stop=%0d, want %0d", stop, BM);
    end
    dones = 0;
    for (int k = 0; k < GAP + 6; k++) begin
      if (tx_done === 1'b1) dones++;
      @(negedge clk);
    end
    n_tests++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL loop_done: pulses=%0d, want 1", dones);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(32'hA5A5_A5A5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ir_env !== 1'b0 || ir_out !== 1'b0 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: env=%b out=%b ready=%b done=%b, want 0 0 1 0",
               ir_env, ir_out, tx_ready, tx_done);
    end
    rst = 1'b0;
    check_idle_after("post_reset");
    send(32'h1234_5678);
    check_frame(32'h1234_5678, "after_reset", NONE, 1'b0, 32'h0);
    check_idle_after("after_reset");
  endtask

  // tx_valid held high: next frame is accepted on the tx_done cycle.
  task automatic test_back_to_back();
    tx_valid = 1'b1;
    tx_data  = 32'h0000_FFFF;
    @(negedge clk);
    check_frame(32'h0000_FFFF, "b2b_a", NONE, 1'b1, 32'h8000_0001);
    @(negedge clk);
    check_frame(32'h8000_0001, "b2b_b", NONE, 1'b0, 32'h0);
    check_idle_after("b2b_b");
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_zero_word();
    test_ones_ignore_valid();
    test_loopback();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
